// File: rtl/l1_tag_ctrl.sv
// L1 tag controller: valid bits, hit/victim selection, refill install and flush.
// Define L1_TAG_FLUSH_EN to build the invalidate-all FLUSH state and set counter.
module l1_tag_ctrl #(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    parameter int TAG_BITS = 22,
    localparam int INDEX_BITS = $clog2(NUM_SETS),
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [INDEX_BITS-1:0]        req_index,
    input  logic [TAG_BITS-1:0]          req_tag,
    output logic                         rsp_valid,
    output logic                         rsp_hit,
    output logic [WAY_BITS-1:0]          rsp_way,
    input  logic                         fill_valid,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic [INDEX_BITS-1:0]        tag_index,
    output logic [TAG_BITS-1:0]          tag_wdata,
    output logic [NUM_WAYS-1:0]          tag_we,
    input  logic [NUM_WAYS*TAG_BITS-1:0] tag_rdata
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOOKUP    = 2'd1;
    localparam logic [1:0] WAIT_FILL = 2'd2;
`ifdef L1_TAG_FLUSH_EN
    localparam logic [1:0] FLUSH     = 2'd3;
`endif

    logic [1:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;
    logic                  vic_rr_q, vic_rr_d;
    logic [WAY_BITS-1:0]   rr_q, rr_d;
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
`ifdef L1_TAG_FLUSH_EN
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;
`else
    logic                  unused_flush;
    assign unused_flush = flush_req;
`endif

    logic [NUM_WAYS-1:0] set_valid;
    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                free;
    logic [WAY_BITS-1:0] free_way;

    assign set_valid = valid_q[idx_q];

    // Descending scan so the lowest matching / lowest free way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] &&
                tag_rdata[w*TAG_BITS +: TAG_BITS] == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!set_valid[w]) begin
                free     = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        victim_d   = victim_q;
        vic_rr_d   = vic_rr_q;
        rr_d       = rr_q;
        valid_d    = valid_q;
`ifdef L1_TAG_FLUSH_EN
        cnt_d      = cnt_q;
`endif
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_hit    = 1'b0;
        rsp_way    = '0;
        flush_done = 1'b0;
        tag_index  = idx_q;
        tag_wdata  = tag_q;
        tag_we     = '0;

        unique case (state_q)
            IDLE: begin
                tag_index = req_index;
`ifdef L1_TAG_FLUSH_EN
                req_ready = !flush_req;
                if (flush_req) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else if (req_valid) begin
                    idx_d   = req_index;
                    tag_d   = req_tag;
                    state_d = LOOKUP;
                end
`else
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d   = req_index;
                    tag_d   = req_tag;
                    state_d = LOOKUP;
                end
`endif
            end
            LOOKUP: begin
                rsp_valid = 1'b1;
                if (hit) begin
                    rsp_hit = 1'b1;
                    rsp_way = hit_way;
                    state_d = IDLE;
                end else begin
                    victim_d = free ? free_way : rr_q;
                    vic_rr_d = !free;
                    rsp_way  = victim_d;
                    state_d  = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (fill_valid) begin
                    tag_we[victim_q]          = 1'b1;
                    valid_d[idx_q][victim_q]  = 1'b1;
                    if (vic_rr_q) begin
                        if (rr_q == WAY_BITS'(NUM_WAYS - 1))
                            rr_d = '0;
                        else
                            rr_d = rr_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
`ifdef L1_TAG_FLUSH_EN
            FLUSH: begin
                tag_index      = cnt_q;
                valid_d[cnt_q] = '0;
                if (cnt_q == INDEX_BITS'(NUM_SETS - 1)) begin
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tag_q    <= '0;
            victim_q <= '0;
            vic_rr_q <= 1'b0;
            rr_q     <= '0;
            valid_q  <= '{default: '0};
`ifdef L1_TAG_FLUSH_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            vic_rr_q <= vic_rr_d;
            rr_q     <= rr_d;
            valid_q  <= valid_d;
`ifdef L1_TAG_FLUSH_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_l1_tag_ctrl.sv
// Bench for l1_tag_ctrl: directed table, randomized ops vs. a set/way model,
// reset-during-fill and flush (or flush-ignored) sequences.
module tb_l1_tag_ctrl;

    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int TB   = 22;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [5:0]      req_index;
    logic [TB-1:0]   req_tag;
    logic            rsp_valid;
    logic            rsp_hit;
    logic [1:0]      rsp_way;
    logic            fill_valid;
    logic            flush_req;
    logic            flush_done;
    logic [5:0]      tag_index;
    logic [TB-1:0]   tag_wdata;
    logic [WAYS-1:0] tag_we;
    logic [WAYS*TB-1:0] tag_rdata;

    l1_tag_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_way    (rsp_way),
        .fill_valid (fill_valid),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .tag_index  (tag_index),
        .tag_wdata  (tag_wdata),
        .tag_we     (tag_we),
        .tag_rdata  (tag_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External tag arrays, one per way.
    logic [TB-1:0] tmem [WAYS][SETS];

    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++)
            if (tag_we[w]) tmem[w][tag_index] <= tag_wdata;
    end

    always_comb begin
        tag_rdata = '0;
        for (int w = 0; w < WAYS; w++)
            tag_rdata[w*TB +: TB] = tmem[w][tag_index];
    end

    // Reference model: per set/way valid + tag, global round-robin pointer.
    bit mvalid [SETS][WAYS];
    int mtag   [SETS][WAYS];
    int mrr;

    int checks = 0;
    int errors = 0;
    int sidx [4] = '{0, 1, 2, 63};

    typedef struct {
        int idx;
        int tag;
        bit hit;
        int way;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void model_clear_valid();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                mvalid[s][w] = 0;
    endfunction

    function automatic void mpredict(input int idx, input int tag,
                                     output bit h, output int way,
                                     output bit from_rr);
        h = 0;
        way = 0;
        from_rr = 0;
        for (int w = 0; w < WAYS; w++)
            if (!h && mvalid[idx][w] && mtag[idx][w] == tag) begin
                h = 1;
                way = w;
            end
        if (!h) begin
            bit found = 0;
            for (int w = 0; w < WAYS; w++)
                if (!found && !mvalid[idx][w]) begin
                    found = 1;
                    way = w;
                end
            if (!found) begin
                way = mrr;
                from_rr = 1;
            end
        end
    endfunction

    function automatic void mfill(input int idx, input int tag,
                                  input int way, input bit from_rr);
        mvalid[idx][way] = 1;
        mtag[idx][way] = tag;
        if (from_rr) mrr = (mrr + 1) % WAYS;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1.
    task automatic lookup(input int idx, input int tag,
                          output logic h, output int way);
        req_valid = 1'b1;
        req_index = 6'(idx);
        req_tag   = TB'(tag);
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("lookup_we", tag_we, 0);
        h = rsp_hit;
        way = int'(rsp_way);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string nm, input int idx, input int tag,
                      input bit use_tbl, input bit thit, input int tway,
                      input int wcyc);
        bit mh, mr;
        int mw, dw, ew;
        logic dh;
        bit eh;
        mpredict(idx, tag, mh, mw, mr);
        eh = use_tbl ? thit : mh;
        ew = use_tbl ? tway : mw;
        lookup(idx, tag, dh, dw);
        chk({nm, "_hit"}, 64'(dh), 64'(eh));
        chk({nm, "_way"}, 64'(dw), 64'(ew));
        if (!eh) begin
            repeat (wcyc) begin
                @(negedge clk);
                chk("wait_ready", req_ready, 0);
                chk("wait_we", tag_we, 0);
                chk("wait_rsp", rsp_valid, 0);
                @(posedge clk);
                #1;
            end
            fill_valid = 1'b1;
            @(negedge clk);
            chk({nm, "_fill_we"}, tag_we, 64'd1 << ew);
            chk({nm, "_fill_idx"}, tag_index, 64'(idx));
            chk({nm, "_fill_wdata"}, tag_wdata, 64'(TB'(tag)));
            @(posedge clk);
            #1;
            fill_valid = 1'b0;
            mfill(idx, tag, mw, mr);
        end
    endtask

    initial begin
        logic dh;
        int dw;
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                tmem[w][s] = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_index  = '0;
        req_tag    = '0;
        fill_valid = 1'b0;
        flush_req  = 1'b0;
        model_clear_valid();
        mrr = 0;

        tbl[0]  = '{5,  'h1234, 0, 0};
        tbl[1]  = '{5,  'h1234, 1, 0};
        tbl[2]  = '{3,  'h0A1,  0, 0};
        tbl[3]  = '{3,  'h0A2,  0, 1};
        tbl[4]  = '{3,  'h0A3,  0, 2};
        tbl[5]  = '{3,  'h0A4,  0, 3};
        tbl[6]  = '{3,  'h0A5,  0, 0};
        tbl[7]  = '{3,  'h0A6,  0, 1};
        tbl[8]  = '{3,  'h0A5,  1, 0};
        tbl[9]  = '{3,  'h0A6,  1, 1};
        tbl[10] = '{3,  'h0A3,  1, 2};
        tbl[11] = '{3,  'h0A7,  0, 2};
        tbl[12] = '{5,  'h1234, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_way", rsp_way, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_flush_done", flush_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            op($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].tag, 1,
               tbl[i].hit, tbl[i].way, i % 3);

        // fill_valid outside WAIT_FILL must not write.
        fill_valid = 1'b1;
        @(negedge clk);
        chk("idle_fill_we", tag_we, 0);
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        op("after_idle_fill", 5, 'h1234, 1, 1, 0, 0);

        for (int i = 0; i < 250; i++) begin
            int r = $urandom_range(0, 5);
            int t = (r == 5) ? 'h3FFFFF : r;
            op("rnd", sidx[$urandom_range(0, 3)], t, 0, 0, 0,
               $urandom_range(0, 3));
        end

`ifdef L1_TAG_FLUSH_EN
        begin
            int seen = 0;
            flush_req = 1'b1;
            req_valid = 1'b1;
            req_index = 6'd9;
            req_tag   = 'h55;
            @(negedge clk);
            chk("flush_prio_ready", req_ready, 0);
            chk("flush_done_early", flush_done, 0);
            @(posedge clk);
            #1;
            flush_req = 1'b0;
            req_valid = 1'b0;
            for (int k = 1; k <= 200 && seen == 0; k++) begin
                @(negedge clk);
                if (flush_done) seen = k;
            end
            chk("flush_done_cycle", 64'(seen), 64);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("flush_done_pulse", flush_done, 0);
            chk("flush_back_idle", req_ready, 1);
            @(posedge clk);
            #1;
            model_clear_valid();
            op("post_flush", 5, 'h1234, 1, 0, 0, 0);
        end
`else
        flush_req = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk("noflush_done", flush_done, 0);
            chk("noflush_ready", req_ready, 1);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 20; k++) begin
            op("noflush_hit5", 5, 'h1234, 1, 1, 0, 0);
            @(negedge clk);
            chk("noflush_done_op", flush_done, 0);
            @(posedge clk);
            #1;
        end
        flush_req = 1'b0;
`endif

        // Reset while waiting for a refill.
        lookup(7, 'h2AAAA, dh, dw);
        chk("pre_rst_miss", 64'(dh), 0);
        chk("pre_rst_way", 64'(dw), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", tag_we, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_done", flush_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear_valid();
        mrr = 0;
        fill_valid = 1'b1;
        @(negedge clk);
        chk("postrst_fill_we", tag_we, 0);
        chk("postrst_idle", req_ready, 1);
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        op("postrst5", 5, 'h1234, 1, 0, 0, 1);
        op("postrst5_hit", 5, 'h1234, 1, 1, 0, 0);
        op("postrst7", 7, 'h2AAAA, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
